// File: rtl/axon_dispatcher.sv
// Initiator side of the axon->neuron synapse lookup: walks the latched spike
// bitmap, requests each spiking axon from the responder and forwards its events.
module axon_dispatcher #(
  parameter int NUM_AXONS      = 256,
  parameter int NUM_NEURONS    = 256,
  parameter int TIMEOUT        = 1024,
  parameter int RECOVER_CYCLES = 2,
  localparam int AW  = $clog2(NUM_AXONS),
  localparam int NW  = $clog2(NUM_NEURONS),
  localparam int WDW = $clog2(TIMEOUT + 1),
  localparam int RCW = $clog2(RECOVER_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [NUM_AXONS-1:0] axon_spikes,
  output logic [AW-1:0]        axon_number,
  output logic                 enable,
  input  logic                 synap_con_done,
  input  logic [NW-1:0]        neuron_number,
  input  logic                 neuron_number_valid,
  output logic                 event_valid,
  output logic [AW-1:0]        event_axon,
  output logic [NW-1:0]        event_neuron,
  output logic                 busy,
  output logic                 tick_done,
  output logic [15:0]          event_count,
  output logic                 timeout_err,
  output logic                 tick_overrun
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_REQ, S_RECOVER, S_FINISH} state_t;

  state_t               state_q, state_d;
  logic [NUM_AXONS-1:0] pending_q, pending_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [AW-1:0]        axon_number_q, axon_number_d;
  logic                 enable_q, enable_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic [RCW-1:0]       rc_q, rc_d;
  logic                 event_valid_q, event_valid_d;
  logic [AW-1:0]        event_axon_q, event_axon_d;
  logic [NW-1:0]        event_neuron_q, event_neuron_d;
  logic                 busy_q, busy_d;
  logic                 tick_done_q, tick_done_d;
  logic [15:0]          event_count_q, event_count_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 tick_overrun_q, tick_overrun_d;

  localparam logic [AW-1:0]  LAST_AXON = AW'(NUM_AXONS - 1);
  localparam logic [WDW-1:0] WD_LIMIT  = WDW'(TIMEOUT - 1);
  localparam logic [RCW-1:0] RC_LOAD   = RCW'(RECOVER_CYCLES);

  // Next-state, request sequencing and event forwarding.
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    ptr_d          = ptr_q;
    axon_number_d  = axon_number_q;
    enable_d       = enable_q;
    wd_d           = wd_q;
    rc_d           = rc_q;
    event_valid_d  = 1'b0;
    event_axon_d   = event_axon_q;
    event_neuron_d = event_neuron_q;
    busy_d         = busy_q;
    tick_done_d    = 1'b0;
    event_count_d  = event_count_q;
    timeout_err_d  = timeout_err_q;
    tick_overrun_d = tick_overrun_q;

    // axon_number is held through RECOVER, so late pulses tag the axon just served.
    if (neuron_number_valid && (state_q != S_IDLE) && (state_q != S_FINISH)) begin
      event_valid_d  = 1'b1;
      event_axon_d   = axon_number_q;
      event_neuron_d = neuron_number;
      if (event_count_q != 16'hFFFF) begin
        event_count_d = event_count_q + 16'd1;
      end else begin
        event_count_d = event_count_q;
      end
    end else begin
      event_valid_d = 1'b0;
    end

    if (tick && busy_q) begin
      tick_overrun_d = 1'b1;
    end else begin
      tick_overrun_d = tick_overrun_d;
    end

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          pending_d      = axon_spikes;
          ptr_d          = {AW{1'b0}};
          event_count_d  = 16'd0;
          timeout_err_d  = 1'b0;
          tick_overrun_d = 1'b0;
          busy_d         = 1'b1;
          state_d        = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (pending_q[ptr_q]) begin
          axon_number_d = ptr_q;
          enable_d      = 1'b1;
          wd_d          = {WDW{1'b0}};
          state_d       = S_REQ;
        end else if (ptr_q == LAST_AXON) begin
          state_d = S_FINISH;
        end else begin
          ptr_d = ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      S_REQ: begin
        if (synap_con_done) begin
          enable_d         = 1'b0;
          pending_d[ptr_q] = 1'b0;
          rc_d             = RC_LOAD;
          state_d          = S_RECOVER;
        end else if (wd_q == WD_LIMIT) begin
          enable_d         = 1'b0;
          timeout_err_d    = 1'b1;
          pending_d[ptr_q] = 1'b0;
          rc_d             = RC_LOAD;
          state_d          = S_RECOVER;
        end else begin
          wd_d = wd_q + {{(WDW-1){1'b0}}, 1'b1};
        end
      end
      S_RECOVER: begin
        // Leave once the decrement reaches zero.
        if (rc_q <= {{(RCW-1){1'b0}}, 1'b1}) begin
          rc_d = {RCW{1'b0}};
          if (ptr_q == LAST_AXON) begin
            state_d = S_FINISH;
          end else begin
            ptr_d   = ptr_q + {{(AW-1){1'b0}}, 1'b1};
            state_d = S_SCAN;
          end
        end else begin
          rc_d = rc_q - {{(RCW-1){1'b0}}, 1'b1};
        end
      end
      S_FINISH: begin
        tick_done_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      pending_q      <= {NUM_AXONS{1'b0}};
      ptr_q          <= {AW{1'b0}};
      axon_number_q  <= {AW{1'b0}};
      enable_q       <= 1'b0;
      wd_q           <= {WDW{1'b0}};
      rc_q           <= {RCW{1'b0}};
      event_valid_q  <= 1'b0;
      event_axon_q   <= {AW{1'b0}};
      event_neuron_q <= {NW{1'b0}};
      busy_q         <= 1'b0;
      tick_done_q    <= 1'b0;
      event_count_q  <= 16'd0;
      timeout_err_q  <= 1'b0;
      tick_overrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      ptr_q          <= ptr_d;
      axon_number_q  <= axon_number_d;
      enable_q       <= enable_d;
      wd_q           <= wd_d;
      rc_q           <= rc_d;
      event_valid_q  <= event_valid_d;
      event_axon_q   <= event_axon_d;
      event_neuron_q <= event_neuron_d;
      busy_q         <= busy_d;
      tick_done_q    <= tick_done_d;
      event_count_q  <= event_count_d;
      timeout_err_q  <= timeout_err_d;
      tick_overrun_q <= tick_overrun_d;
    end
  end

  assign axon_number  = axon_number_q;
  assign enable       = enable_q;
  assign event_valid  = event_valid_q;
  assign event_axon   = event_axon_q;
  assign event_neuron = event_neuron_q;
  assign busy         = busy_q;
  assign tick_done    = tick_done_q;
  assign event_count  = event_count_q;
  assign timeout_err  = timeout_err_q;
  assign tick_overrun = tick_overrun_q;

endmodule
